// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the MAC-to-activation datapath.
//   mac_state_e  : sequencing states of the MAC stream unit.
//   *_DEF        : default operand / accumulator / result widths.
//   sat_narrow() : arithmetic right shift plus narrowing to OUT_W_DEF bits.
// Configuration macro: MAC_STREAM_SAT_EN
//   defined   -> narrowing saturates to the signed OUT_W_DEF range
//   undefined -> narrowing keeps the low OUT_W_DEF bits (two's-complement wrap)
package mac_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    FINAL = 2'd2
  } mac_state_e;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 24;
  localparam int unsigned OUT_W_DEF  = 16;

  // Accumulators are sign-extended to this width before narrowing so one
  // function serves every accumulator width up to 64 bits.
  localparam int unsigned NARROW_W = 64;

  localparam logic signed [NARROW_W-1:0] OUT_MAX =
    (64'sd1 <<< (OUT_W_DEF - 1)) - 64'sd1;
  localparam logic signed [NARROW_W-1:0] OUT_MIN =
    -(64'sd1 <<< (OUT_W_DEF - 1));

  // >>> on a signed operand floors toward negative infinity.
  function automatic logic [OUT_W_DEF-1:0] sat_narrow(
    input logic signed [NARROW_W-1:0] acc,
    input int unsigned                shift
  );
`ifdef MAC_STREAM_SAT_EN
    logic signed [NARROW_W-1:0] s;
    s = acc >>> shift;
    if (s > OUT_MAX) begin
      return OUT_MAX[OUT_W_DEF-1:0];
    end else if (s < OUT_MIN) begin
      return OUT_MIN[OUT_W_DEF-1:0];
    end else begin
      return s[OUT_W_DEF-1:0];
    end
`else
    return OUT_W_DEF'(acc >>> shift);
`endif
  endfunction

endpackage

// File: rtl/mac_stream_unit.sv
// mac_stream_unit: streams signed operand pairs, accumulates VEC_LEN-long dot
// products and emits one narrowed result per vector as a one-cycle strobe.
// Ports:
//   clk        clock
//   reset_n    synchronous active-low reset (priority over clear)
//   clear      synchronous flush, aborts the vector in progress, holds mac_out
//   a_in/b_in  signed operands, sampled only when in_valid && in_ready
//   in_valid   operand pair valid
//   in_ready   unit can accept a pair (ACCUM state only)
//   mac_out    signed result, held between strobes
//   valid_out  one-cycle result strobe, 3 clocks after the last beat
// Configuration macro: MAC_STREAM_SAT_EN (saturating narrowing; see mac_pkg).
module mac_stream_unit
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned VEC_LEN    = 4,
  parameter int unsigned ACC_W      = ACC_W_DEF,
  parameter int unsigned OUT_W      = OUT_W_DEF,
  parameter int unsigned FRAC_SHIFT = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  mac_out,
  output logic              valid_out
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = $clog2(VEC_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VEC_LEN - 1);

  if (VEC_LEN < 2) begin : g_chk_vec
    $error("mac_stream_unit: VEC_LEN must be >= 2");
  end
  if (ACC_W < PROD_W + $clog2(VEC_LEN)) begin : g_chk_acc
    $error("mac_stream_unit: ACC_W too narrow for VEC_LEN products");
  end
  if (ACC_W > NARROW_W) begin : g_chk_acc_max
    $error("mac_stream_unit: ACC_W exceeds narrowing width");
  end
  if (OUT_W != OUT_W_DEF) begin : g_chk_out
    $error("mac_stream_unit: OUT_W is fixed to the activation input width");
  end

  mac_state_e               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic                     pv_q, pv_d;
  logic [OUT_W-1:0]         out_q, out_d;
  logic                     vo_q, vo_d;
  logic                     accept;

  // Gating ready with reset_n and clear keeps "accepted" identical to
  // in_valid && in_ready, so a beat offered alongside clear is never taken.
  assign in_ready  = reset_n && !clear && (state_q == ACCUM);
  assign accept    = in_valid && in_ready;
  assign mac_out   = out_q;
  assign valid_out = vo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    pv_d    = accept;
    out_d   = out_q;
    vo_d    = 1'b0;

    if (accept) begin
      prod_d = PROD_W'(signed'(a_in)) * PROD_W'(signed'(b_in));
    end

    if (pv_q) begin
      acc_d = acc_q + ACC_W'(prod_q);
    end

    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        state_d = FINAL;
      end
      FINAL: begin
        // No product is pending here, so clearing acc cannot drop a beat.
        out_d   = sat_narrow(NARROW_W'(acc_q), FRAC_SHIFT);
        vo_d    = 1'b1;
        acc_d   = '0;
        state_d = ACCUM;
      end
      default: begin
        state_d = ACCUM;
      end
    endcase

    if (clear) begin
      state_d = ACCUM;
      cnt_d   = '0;
      acc_d   = '0;
      pv_d    = 1'b0;
      vo_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      pv_q    <= 1'b0;
      out_q   <= '0;
      vo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      pv_q    <= pv_d;
      out_q   <= out_d;
      vo_q    <= vo_d;
    end
  end

endmodule

// File: tb/tb_mac_stream_unit.sv
// tb_mac_stream_unit: scoreboard bench for mac_stream_unit. Two instances share
// the stimulus: FRAC_SHIFT=0 and FRAC_SHIFT=4. Expected results are pushed when
// a vector's last beat is accepted; a monitor pops and compares on valid_out.
module tb_mac_stream_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        in_valid;
  logic        in_ready, in_ready4;
  logic [15:0] mac_out, mac_out4;
  logic        valid_out, valid_out4;

  always #5 clk = ~clk;

  mac_stream_unit #(.DATA_W(8), .VEC_LEN(4), .ACC_W(24), .OUT_W(16), .FRAC_SHIFT(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .a_in(a_in), .b_in(b_in),
    .in_valid(in_valid), .in_ready(in_ready), .mac_out(mac_out), .valid_out(valid_out)
  );

  mac_stream_unit #(.DATA_W(8), .VEC_LEN(4), .ACC_W(24), .OUT_W(16), .FRAC_SHIFT(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .a_in(a_in), .b_in(b_in),
    .in_valid(in_valid), .in_ready(in_ready4), .mac_out(mac_out4), .valid_out(valid_out4)
  );

`ifdef MAC_STREAM_SAT_EN
  localparam logic [15:0] E_POS_OVF = 16'h7FFF;
  localparam logic [15:0] E_M128SQ  = 16'h7FFF;
  localparam logic [15:0] E_NEG_OVF = 16'h8000;
`else
  localparam logic [15:0] E_POS_OVF = 16'hFC04;
  localparam logic [15:0] E_M128SQ  = 16'h0000;
  localparam logic [15:0] E_NEG_OVF = 16'h0200;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_cyc = 0;

  logic [15:0] q0[$];
  logic [15:0] q4[$];
  int          qc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per strobe and checks value and latency.
  always @(negedge clk) begin
    logic [15:0] e;
    int c;
    if (valid_out === 1'b1) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got strobe expected none (t=%0t)", $time);
      end else begin
        e = q0.pop_front();
        c = qc.pop_front();
        chk("mac_out", 32'(mac_out), 32'(e));
        chk("latency_cycles", cyc, c + 2);
      end
    end
    if (valid_out4 === 1'b1) begin
      if (q4.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid_shift4: got strobe expected none (t=%0t)", $time);
      end else begin
        e = q4.pop_front();
        chk("mac_out_shift4", 32'(mac_out4), 32'(e));
      end
    end
  end

  // Holds the pair until in_ready is seen high ahead of an edge.
  task automatic send_beat(input logic [7:0] a, input logic [7:0] b);
    logic ok;
    int   t;
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    ok = 1'b0;
    t  = 0;
    while (!ok) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      t++;
      if (!ok && t > 20) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ready_timeout: got in_ready=0 for %0d cycles expected 1", t);
        break;
      end
    end
    in_valid = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic send_vec(input logic [3:0][7:0] a, input logic [3:0][7:0] b,
                          input int maxgap, input logic [15:0] e0, input logic [15:0] e4);
    int g;
    for (int i = 0; i < 4; i++) begin
      send_beat(a[i], b[i]);
      if (maxgap > 0 && i < 3) begin
        g = int'($urandom_range(maxgap, 0));
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
    end
    q0.push_back(e0);
    q4.push_back(e4);
    qc.push_back(last_cyc);
  endtask

  // Vector {1,2,3,4}.{5,6,7,8}; index 0 is the first beat.
  localparam logic [3:0][7:0] VA1 = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [3:0][7:0] VB1 = {8'd8, 8'd7, 8'd6, 8'd5};

  initial begin
    int t;
    reset_n  = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    a_in     = '0;
    b_in     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("ready_in_reset", 32'(in_ready), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("reset_mac_out", 32'(mac_out), 32'd0);
    chk("reset_valid_out", 32'(valid_out), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Test 1: back-to-back, ready low for two cycles, strobe in the third.
    send_vec(VA1, VB1, 0, 16'h0046, 16'h0004);
    @(negedge clk);
    chk("ready_drain", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("ready_final", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("ready_back", 32'(in_ready), 32'd1);
    chk("valid_with_ready", 32'(valid_out), 32'd1);
    @(posedge clk);
    #1;

    // Test 2: negative result, floor shift.
    send_vec({4{8'hF6}}, {4{8'h14}}, 0, 16'hFCE0, 16'hFFCE);
    // Test 3: overflow in both directions.
    send_vec({4{8'h7F}}, {4{8'h7F}}, 0, E_POS_OVF, 16'h0FC0);
    send_vec({4{8'h80}}, {4{8'h80}}, 0, E_M128SQ, 16'h1000);
    send_vec({4{8'h80}}, {4{8'h7F}}, 0, E_NEG_OVF, 16'hF020);
    // -1 >>> 4 floors to -1.
    send_vec({8'd0, 8'd0, 8'd0, 8'hFF}, {8'd0, 8'd0, 8'd0, 8'd1}, 0, 16'hFFFF, 16'hFFFF);

    // Test 4: random gaps then an immediate follow-on vector.
    send_vec(VA1, VB1, 3, 16'h0046, 16'h0004);
    send_vec({4{8'd1}}, {4{8'd1}}, 0, 16'h0004, 16'h0000);
    repeat (5) @(posedge clk);
    #1;

    // Test 5a: reset mid-vector.
    send_beat(8'd1, 8'd5);
    send_beat(8'd2, 8'd6);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("midreset_mac_out", 32'(mac_out), 32'd0);
    chk("midreset_mac_out_shift4", 32'(mac_out4), 32'd0);
    chk("midreset_valid_out", 32'(valid_out), 32'd0);
    chk("midreset_in_ready", 32'(in_ready), 32'd1);
    send_vec(VA1, VB1, 0, 16'h0046, 16'h0004);
    repeat (5) @(posedge clk);
    #1;

    // Test 5b: clear mid-vector with a beat offered alongside it.
    send_beat(8'd1, 8'd5);
    send_beat(8'd2, 8'd6);
    clear    = 1'b1;
    a_in     = 8'd50;
    b_in     = 8'd50;
    in_valid = 1'b1;
    #1;
    chk("ready_during_clear", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("clear_holds_mac_out", 32'(mac_out), 32'h0046);
    chk("clear_holds_mac_out_shift4", 32'(mac_out4), 32'h0004);
    chk("clear_valid_out", 32'(valid_out), 32'd0);
    chk("clear_in_ready", 32'(in_ready), 32'd1);
    send_vec(VA1, VB1, 0, 16'h0046, 16'h0004);

    t = 0;
    while ((q0.size() != 0 || q4.size() != 0) && t < 50) begin
      @(posedge clk);
      t++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("pending_results", 32'(q0.size() + q4.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
